// File: rtl/rps_match_scorer_if.sv
// Scorer bus: play key, choices and opponent channels in; scores, flags and strobes out.
// No storage here; opp_ready is the only flow control (the scorer waits on it).
interface rps_match_scorer_if #(
    parameter int SCORE_W = 8,
    parameter int NUM_OPP = 3
);
    logic                   start_n;
    logic [1:0]             user_choice;
    logic [1:0]             opp_sel;
    logic [2*NUM_OPP-1:0]   opp_choice;
    logic [NUM_OPP-1:0]     opp_ready;
    logic [1:0]             com_loaded;
    logic [SCORE_W-1:0]     user_score;
    logic [SCORE_W-1:0]     com_score;
    logic                   uwin;
    logic                   cwin;
    logic                   equ;
    logic [SCORE_W-1:0]     round_count;
    logic                   round_valid;
    logic                   draw_req;
    logic                   illegal;
    logic                   timeout;
    logic                   match_over;
    logic [1:0]             match_winner;

    modport master (
        output start_n, user_choice, opp_sel, opp_choice, opp_ready,
        input  com_loaded, user_score, com_score, uwin, cwin, equ, round_count,
               round_valid, draw_req, illegal, timeout, match_over, match_winner
    );

    modport slave (
        input  start_n, user_choice, opp_sel, opp_choice, opp_ready,
        output com_loaded, user_score, com_score, uwin, cwin, equ, round_count,
               round_valid, draw_req, illegal, timeout, match_over, match_winner
    );
endinterface

// File: rtl/rps_match_scorer.sv
// Rock-paper-scissors round/match scorer; result visible 2 cycles after the synchronised key press.
// Stalls in WAIT_READY until the selected opponent raises ready, aborting after READY_TIMEOUT cycles.
module rps_match_scorer #(
    parameter int SCORE_W       = 8,
    parameter int WIN_TARGET    = 5,
    parameter int NUM_OPP       = 3,
    parameter int READY_TIMEOUT = 1023
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    rps_match_scorer_if.slave   bus
);
    localparam int                 WAIT_W    = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0]  TIMEOUT_L = WAIT_W'(READY_TIMEOUT);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] TARGET_L  = SCORE_W'(WIN_TARGET);
    localparam logic [2:0]         NUM_OPP_L = 3'(NUM_OPP);

    typedef enum logic [1:0] {IDLE, WAIT_READY, RESOLVE, MATCH_OVER} state_t;

    state_t              state_q;
    state_t              state_d;
    logic                sync_a;
    logic                sync_b;
    logic                sync_c;
    logic                start_fall;
    logic [1:0]          sel_eff;
    logic [3:0]          ready_pad;
    logic [7:0]          choice_pad;
    logic                ready_eff;
    logic [1:0]          choice_eff;
    logic [1:0]          user_lat;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic                u_wins;
    logic                c_wins;
    logic [SCORE_W-1:0]  user_nxt;
    logic [SCORE_W-1:0]  com_nxt;
    logic [SCORE_W-1:0]  rnd_nxt;
    logic                accept;
    logic                reject;
    logic                resolve;
    logic                expire;

    // Released key reads as 1, so reset must not fabricate a press.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            sync_c <= 1'b1;
        end else begin
            sync_a <= bus.start_n;
            sync_b <= sync_a;
            sync_c <= sync_b;
        end
    end

    assign start_fall = sync_c & ~sync_b;

    // Padding keeps the channel mux width-independent of NUM_OPP.
    assign sel_eff    = ({1'b0, bus.opp_sel} < NUM_OPP_L) ? bus.opp_sel : 2'd0;
    assign ready_pad  = 4'(bus.opp_ready);
    assign choice_pad = 8'(bus.opp_choice);
    assign ready_eff  = ready_pad[sel_eff];
    assign choice_eff = choice_pad[{sel_eff, 1'b0} +: 2];
    assign wait_nxt   = wait_cnt + WAIT_W'(1);

    assign user_nxt = (bus.user_score  == SCORE_MAX) ? bus.user_score  : bus.user_score  + 1'b1;
    assign com_nxt  = (bus.com_score   == SCORE_MAX) ? bus.com_score   : bus.com_score   + 1'b1;
    assign rnd_nxt  = (bus.round_count == SCORE_MAX) ? bus.round_count : bus.round_count + 1'b1;

    // An opponent answer of 11 falls through as a draw.
    always_comb begin
        u_wins = 1'b0;
        c_wins = 1'b0;
        if (choice_eff != 2'b11 && choice_eff != user_lat) begin
            case ({user_lat, choice_eff})
                4'b00_01, 4'b01_10, 4'b10_00: u_wins = 1'b1;
                default:                      c_wins = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        resolve = 1'b0;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_fall) begin
                    if (bus.user_choice == 2'b11) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = WAIT_READY;
                    end
                end
            end
            WAIT_READY: begin
                if (ready_eff) begin
                    resolve = 1'b1;
                    state_d = RESOLVE;
                end else if (READY_TIMEOUT != 0 && wait_nxt == TIMEOUT_L) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end
            end
            RESOLVE:    state_d = bus.match_over ? MATCH_OVER : IDLE;
            MATCH_OVER: state_d = MATCH_OVER;
            default:    state_d = IDLE;
        endcase
    end

    // Round results land on the edge leaving WAIT_READY; RESOLVE is the cycle they are strobed.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            user_lat         <= 2'b00;
            wait_cnt         <= '0;
            bus.com_loaded   <= 2'b00;
            bus.user_score   <= '0;
            bus.com_score    <= '0;
            bus.uwin         <= 1'b0;
            bus.cwin         <= 1'b0;
            bus.equ          <= 1'b0;
            bus.round_count  <= '0;
            bus.round_valid  <= 1'b0;
            bus.illegal      <= 1'b0;
            bus.timeout      <= 1'b0;
            bus.match_over   <= 1'b0;
            bus.match_winner <= 2'b00;
        end else begin
            bus.round_valid <= resolve;
            bus.illegal     <= reject;
            bus.timeout     <= expire;
            if (accept) begin
                user_lat <= bus.user_choice;
                wait_cnt <= '0;
                bus.uwin <= 1'b0;
                bus.cwin <= 1'b0;
                bus.equ  <= 1'b0;
            end
            if (state_q == WAIT_READY) wait_cnt <= wait_nxt;
            if (resolve) begin
                bus.com_loaded  <= choice_eff;
                bus.uwin        <= u_wins;
                bus.cwin        <= c_wins;
                bus.equ         <= ~(u_wins | c_wins);
                bus.round_count <= rnd_nxt;
                if (u_wins) begin
                    bus.user_score <= user_nxt;
                    if (user_nxt == TARGET_L) begin
                        bus.match_over   <= 1'b1;
                        bus.match_winner <= 2'b01;
                    end
                end
                if (c_wins) begin
                    bus.com_score <= com_nxt;
                    if (com_nxt == TARGET_L) begin
                        bus.match_over   <= 1'b1;
                        bus.match_winner <= 2'b10;
                    end
                end
            end
        end
    end

    assign bus.draw_req = bus.round_valid;
endmodule

// File: tb/tb_rps_match_scorer.sv
// Bench for rps_match_scorer: two instances (default and narrow/short-timeout) on shared stimulus.
// A game-level model predicts every output each cycle; literal checks pin the key scenarios.
module tb_rps_match_scorer;
    logic CLOCK_50;
    logic reset_n;
    bit   chk_en;
    int   n_chk;
    int   n_fail;

    localparam int P_SW [2] = '{8, 2};
    localparam int P_WT [2] = '{5, 3};
    localparam int P_TO [2] = '{1023, 15};

    rps_match_scorer_if #(.SCORE_W(8), .NUM_OPP(3)) bus0 ();
    rps_match_scorer_if #(.SCORE_W(2), .NUM_OPP(3)) bus1 ();

    assign bus1.start_n     = bus0.start_n;
    assign bus1.user_choice = bus0.user_choice;
    assign bus1.opp_sel     = bus0.opp_sel;
    assign bus1.opp_choice  = bus0.opp_choice;
    assign bus1.opp_ready   = bus0.opp_ready;

    rps_match_scorer #(.SCORE_W(8), .WIN_TARGET(5), .NUM_OPP(3), .READY_TIMEOUT(1023)) dut0 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .bus(bus0));
    rps_match_scorer #(.SCORE_W(2), .WIN_TARGET(3), .NUM_OPP(3), .READY_TIMEOUT(15)) dut1 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .bus(bus1));

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Model: game phase 0 idle, 1 waiting for opponent, 2 result strobe, 3 match finished.
    int m_ph [2], m_wcnt [2], m_ul [2], m_com [2], m_us [2], m_cs [2];
    int m_uw [2], m_cw [2], m_eq [2], m_rc [2], m_rv [2], m_il [2], m_to [2], m_mo [2], m_mw [2];
    int key_hist [3];
    int rv_seen [2], il_seen [2], to_seen [2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_wcnt[i] = 0; m_ul[i] = 0; m_com[i] = 0; m_us[i] = 0; m_cs[i] = 0;
            m_uw[i] = 0; m_cw[i] = 0; m_eq[i] = 0; m_rc[i] = 0; m_rv[i] = 0; m_il[i] = 0;
            m_to[i] = 0; m_mo[i] = 0; m_mw[i] = 0;
        end
        for (int k = 0; k < 3; k++) key_hist[k] = 1;
    endtask

    task automatic model_step();
        int fall, s, c, d, mx;
        fall = (key_hist[2] == 1 && key_hist[1] == 0) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 0; m_il[i] = 0; m_to[i] = 0;
            mx = (1 << P_SW[i]) - 1;
            if (m_ph[i] == 0) begin
                if (fall == 1) begin
                    if (int'(bus0.user_choice) == 3) m_il[i] = 1;
                    else begin
                        m_ul[i] = int'(bus0.user_choice);
                        m_uw[i] = 0; m_cw[i] = 0; m_eq[i] = 0;
                        m_wcnt[i] = 0; m_ph[i] = 1;
                    end
                end
            end else if (m_ph[i] == 1) begin
                s = (int'(bus0.opp_sel) < 3) ? int'(bus0.opp_sel) : 0;
                if (bus0.opp_ready[s]) begin
                    c = 2 * int'(bus0.opp_choice[2*s+1]) + int'(bus0.opp_choice[2*s]);
                    m_com[i] = c;
                    d = (c - m_ul[i] + 3) % 3;
                    if (c == 3 || d == 0) begin
                        m_eq[i] = 1;
                    end else if (d == 1) begin
                        m_uw[i] = 1;
                        m_us[i] = (m_us[i] < mx) ? m_us[i] + 1 : mx;
                        if (m_us[i] == P_WT[i]) begin m_mo[i] = 1; m_mw[i] = 1; end
                    end else begin
                        m_cw[i] = 1;
                        m_cs[i] = (m_cs[i] < mx) ? m_cs[i] + 1 : mx;
                        if (m_cs[i] == P_WT[i]) begin m_mo[i] = 1; m_mw[i] = 2; end
                    end
                    m_rc[i] = (m_rc[i] < mx) ? m_rc[i] + 1 : mx;
                    m_rv[i] = 1;
                    m_ph[i] = 2;
                end else begin
                    m_wcnt[i]++;
                    if (P_TO[i] != 0 && m_wcnt[i] == P_TO[i]) begin
                        m_to[i] = 1;
                        m_ph[i] = 0;
                    end
                end
            end else if (m_ph[i] == 2) begin
                m_ph[i] = (m_mo[i] == 1) ? 3 : 0;
            end
        end
        key_hist[2] = key_hist[1];
        key_hist[1] = key_hist[0];
        key_hist[0] = int'(bus0.start_n);
    endtask

    always @(posedge CLOCK_50) begin
        if (!reset_n) model_clear();
        else          model_step();
    end

    task automatic cmp(input string nm, input int i, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] at %0t: got %0d, expected %0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int i, input int com, input int us, input int cs,
                              input int uw, input int cw, input int eq, input int rc,
                              input int rv, input int dr, input int il, input int to,
                              input int mo, input int mw);
        cmp("com_loaded", i, com, m_com[i]);
        cmp("user_score", i, us, m_us[i]);
        cmp("com_score", i, cs, m_cs[i]);
        cmp("uwin", i, uw, m_uw[i]);
        cmp("cwin", i, cw, m_cw[i]);
        cmp("equ", i, eq, m_eq[i]);
        cmp("round_count", i, rc, m_rc[i]);
        cmp("round_valid", i, rv, m_rv[i]);
        cmp("draw_req", i, dr, m_rv[i]);
        cmp("illegal", i, il, m_il[i]);
        cmp("timeout", i, to, m_to[i]);
        cmp("match_over", i, mo, m_mo[i]);
        cmp("match_winner", i, mw, m_mw[i]);
    endtask

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            if (!reset_n) model_clear();
            check_inst(0, bus0.com_loaded, bus0.user_score, bus0.com_score, bus0.uwin, bus0.cwin,
                       bus0.equ, bus0.round_count, bus0.round_valid, bus0.draw_req, bus0.illegal,
                       bus0.timeout, bus0.match_over, bus0.match_winner);
            check_inst(1, bus1.com_loaded, bus1.user_score, bus1.com_score, bus1.uwin, bus1.cwin,
                       bus1.equ, bus1.round_count, bus1.round_valid, bus1.draw_req, bus1.illegal,
                       bus1.timeout, bus1.match_over, bus1.match_winner);
            if (bus0.round_valid) rv_seen[0]++;
            if (bus1.round_valid) rv_seen[1]++;
            if (bus0.illegal) il_seen[0]++;
            if (bus1.illegal) il_seen[1]++;
            if (bus0.timeout) to_seen[0]++;
            if (bus1.timeout) to_seen[1]++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #2;
    endtask

    task automatic do_reset();
        bus0.start_n = 1'b1;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic press(input logic [1:0] uc);
        bus0.user_choice = uc;
        bus0.start_n = 1'b0;
        tick(3);
        bus0.start_n = 1'b1;
        tick(4);
    endtask

    int base;
    int base_to;

    initial begin
        n_chk = 0; n_fail = 0; chk_en = 1'b0;
        reset_n = 1'b1;
        bus0.start_n = 1'b1; bus0.user_choice = 2'b00; bus0.opp_sel = 2'd0;
        bus0.opp_choice = 6'b0; bus0.opp_ready = 3'b0;
        for (int i = 0; i < 2; i++) begin rv_seen[i] = 0; il_seen[i] = 0; to_seen[i] = 0; end
        model_clear();
        #1 reset_n = 1'b0;
        chk_en = 1'b1;
        tick(3);
        cmp("rst_user_score", 0, bus0.user_score, 0);
        cmp("rst_match_over", 0, bus0.match_over, 0);
        cmp("rst_round_count", 1, bus1.round_count, 0);
        reset_n = 1'b1;
        tick(1);

        // Single win on channel 0, with exact latency.
        bus0.opp_ready = 3'b111; bus0.opp_choice = 6'b10_00_01; bus0.user_choice = 2'b00;
        base = rv_seen[0];
        bus0.start_n = 1'b0;
        tick(3);
        cmp("lat_rv_early", 0, bus0.round_valid, 0);
        bus0.start_n = 1'b1;
        tick(1);
        cmp("win_uwin", 0, bus0.uwin, 1);
        cmp("win_user_score", 0, bus0.user_score, 1);
        cmp("win_com_score", 0, bus0.com_score, 0);
        cmp("win_com_loaded", 0, bus0.com_loaded, 1);
        cmp("win_round_valid", 0, bus0.round_valid, 1);
        cmp("win_draw_req", 0, bus0.draw_req, 1);
        tick(1);
        cmp("win_rv_one_cycle", 0, bus0.round_valid, 0);
        tick(3);
        cmp("win_rv_pulses", 0, rv_seen[0] - base, 1);

        // Held key counts once.
        do_reset();
        bus0.user_choice = 2'b10; bus0.opp_choice = 6'b00_00_10;
        base = rv_seen[0];
        bus0.start_n = 1'b0;
        tick(100);
        bus0.start_n = 1'b1;
        tick(5);
        cmp("hold_equ", 0, bus0.equ, 1);
        cmp("hold_round_count", 0, bus0.round_count, 1);
        cmp("hold_scores", 0, int'(bus0.user_score) + int'(bus0.com_score), 0);
        cmp("hold_rv_pulses", 0, rv_seen[0] - base, 1);

        // Slow opponent on channel 2; dut1 gives up after 15 cycles.
        do_reset();
        bus0.opp_sel = 2'd2; bus0.opp_ready = 3'b011; bus0.user_choice = 2'b01;
        bus0.opp_choice = 6'b00_10_10;
        base = rv_seen[0]; base_to = to_seen[1];
        bus0.start_n = 1'b0;
        tick(3);
        bus0.start_n = 1'b1;
        tick(14);
        cmp("to_early", 1, bus1.timeout, 0);
        tick(1);
        cmp("to_pulse", 1, bus1.timeout, 1);
        tick(1);
        cmp("to_one_cycle", 1, bus1.timeout, 0);
        tick(4);
        cmp("wait_no_round", 0, rv_seen[0] - base, 0);
        cmp("to_pulses", 1, to_seen[1] - base_to, 1);
        bus0.opp_ready = 3'b111;
        tick(3);
        cmp("wait_cwin", 0, bus0.cwin, 1);
        cmp("wait_com_score", 0, bus0.com_score, 1);
        cmp("to_com_score", 1, bus1.com_score, 0);
        cmp("to_round_count", 1, bus1.round_count, 0);

        // Illegal press, then out-of-range opponent index.
        base = il_seen[0];
        press(2'b11);
        cmp("ill_pulses", 0, il_seen[0] - base, 1);
        cmp("ill_cwin_kept", 0, bus0.cwin, 1);
        cmp("ill_com_score", 0, bus0.com_score, 1);
        bus0.opp_sel = 2'd3; bus0.opp_choice = 6'b10_00_01;
        press(2'b00);
        cmp("sel3_uwin", 0, bus0.uwin, 1);
        cmp("sel3_com_loaded", 0, bus0.com_loaded, 1);

        // Match to WIN_TARGET.
        do_reset();
        bus0.opp_sel = 2'd0;
        repeat (5) press(2'b00);
        cmp("match_over", 0, bus0.match_over, 1);
        cmp("match_winner", 0, bus0.match_winner, 1);
        cmp("match_user_score", 0, bus0.user_score, 5);
        cmp("match_over", 1, bus1.match_over, 1);
        cmp("match_user_score", 1, bus1.user_score, 3);
        base = rv_seen[0];
        press(2'b00);
        cmp("over_no_round", 0, rv_seen[0] - base, 0);
        cmp("over_user_score", 0, bus0.user_score, 5);
        do_reset();
        cmp("post_rst_score", 0, bus0.user_score, 0);
        cmp("post_rst_winner", 0, bus0.match_winner, 0);

        // Reset while the second win resolves, then saturate round_count.
        do_reset();
        base = rv_seen[1];
        press(2'b00);
        bus0.start_n = 1'b0;
        tick(3);
        reset_n = 1'b0;
        tick(3);
        bus0.start_n = 1'b1;
        reset_n = 1'b1;
        tick(2);
        cmp("abort_user_score", 1, bus1.user_score, 0);
        cmp("abort_rv_pulses", 1, rv_seen[1] - base, 1);
        bus0.opp_choice = 6'b10_00_00;
        repeat (5) press(2'b00);
        cmp("sat_round_count", 1, bus1.round_count, 3);
        cmp("sat_round_count", 0, bus0.round_count, 5);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            reset_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) bus0.start_n = ~bus0.start_n;
            if ($urandom_range(0, 3) == 0) bus0.user_choice = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) bus0.opp_sel = 2'($urandom_range(0, 3));
            bus0.opp_choice = 6'($urandom);
            bus0.opp_ready  = (k % 200 < 25) ? 3'b000 : 3'($urandom);
            tick(1);
        end
        reset_n = 1'b1;
        tick(4);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
